// File: rtl/adjust_ctrl.sv
// Push-button adjustment controller: synchronizes/debounces four keys and drives
// one-hot inc/dec/reset strobes with hold-to-repeat into the selected filter stage.

module adjust_ctrl_deb #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_lvl
);
  localparam int CW = $clog2(DEBOUNCE) + 1;

  logic [1:0]    r_sync;
  logic          r_clean;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_clean <= ~r_clean;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_lvl = r_clean;
endmodule

module adjust_ctrl #(
  parameter int NUM_TGT      = 4,
  parameter int DEBOUNCE     = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_sel,
  input  logic               btn_clr,
  output logic [NUM_TGT-1:0] inc,
  output logic [NUM_TGT-1:0] dec,
  output logic [NUM_TGT-1:0] tgt_rst,
  output logic [2:0]         sel,
  output logic               repeating
);
  localparam int NBTN = 4;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] T_DLY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_RATE = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT, S_LOCK} state_t;

  logic [NBTN-1:0]    w_raw, w_lvl;
  logic [1:0]         r_prev;
  logic               w_u, w_d, w_sel_rise, w_clr_rise, w_held, w_opp;
  state_t             r_state, w_nstate;
  logic               r_dir, w_ndir;
  logic [TW-1:0]      r_timer, w_ntimer;
  logic [2:0]         r_sel, w_nsel;
  logic               w_pinc, w_pdec, w_ptrst;
  logic [NUM_TGT-1:0] r_inc, r_dec, r_trst, w_oh;

  assign w_raw = {btn_clr, btn_sel, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      adjust_ctrl_deb #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .i_raw (w_raw[gi]),
        .o_lvl (w_lvl[gi])
      );
    end
  endgenerate

  assign w_u        = w_lvl[0];
  assign w_d        = w_lvl[1];
  assign w_sel_rise = w_lvl[2] & ~r_prev[0];
  assign w_clr_rise = w_lvl[3] & ~r_prev[1];
  assign w_held     = r_dir ? w_u : w_d;
  assign w_opp      = r_dir ? w_d : w_u;
  assign w_oh       = {{(NUM_TGT-1){1'b0}}, 1'b1} << r_sel;

  // Clear beats select beats the up/down machine; both force LOCKOUT.
  always_comb begin
    w_nstate = r_state;
    w_ndir   = r_dir;
    w_ntimer = r_timer;
    w_nsel   = r_sel;
    w_pinc   = 1'b0;
    w_pdec   = 1'b0;
    w_ptrst  = 1'b0;
    if (w_clr_rise) begin
      w_ptrst  = 1'b1;
      w_nstate = S_LOCK;
    end else if (w_sel_rise) begin
      w_nsel   = (r_sel == 3'(NUM_TGT - 1)) ? 3'd0 : r_sel + 3'd1;
      w_nstate = S_LOCK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_u && w_d) begin
            w_nstate = S_LOCK;
          end else if (w_u || w_d) begin
            w_pinc   = w_u;
            w_pdec   = w_d;
            w_ndir   = w_u;
            w_ntimer = T_DLY;
            w_nstate = S_WAIT;
          end
        end
        S_WAIT, S_REPEAT: begin
          if (!w_held) begin
            w_nstate = S_IDLE;
          end else if (w_opp) begin
            w_nstate = S_LOCK;
          end else if (r_timer == '0) begin
            w_pinc   = r_dir;
            w_pdec   = ~r_dir;
            w_ntimer = T_RATE;
            w_nstate = S_REPEAT;
          end else begin
            w_ntimer = r_timer - 1'b1;
          end
        end
        default: begin
          if (!w_u && !w_d) w_nstate = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_timer <= '0;
      r_sel   <= '0;
      r_inc   <= '0;
      r_dec   <= '0;
      r_trst  <= '0;
    end else begin
      r_prev  <= w_lvl[3:2];
      r_state <= w_nstate;
      r_dir   <= w_ndir;
      r_timer <= w_ntimer;
      r_sel   <= w_nsel;
      r_inc   <= w_pinc  ? w_oh : '0;
      r_dec   <= w_pdec  ? w_oh : '0;
      r_trst  <= w_ptrst ? w_oh : '0;
    end
  end

  assign inc       = r_inc;
  assign dec       = r_dec;
  assign tgt_rst   = r_trst;
  assign sel       = r_sel;
  assign repeating = (r_state == S_REPEAT);
endmodule
